// File: rtl/fcu_pkg.sv
// fcu_pkg: shared FCU issue-control state type, queue default and
// the instruction field encodings used to spot a WAIT instruction.
package fcu_pkg;

    localparam int FCU_QENTRIES = 8;
    localparam int FCU_ILEN     = 40;

    localparam logic [3:0] OPC_BMISC = 4'h2;
    localparam logic [4:0] FN5_WAIT  = 5'h0A;

    typedef enum logic [1:0] {
        FCU_IDLE,
        FCU_EXEC,
        FCU_WAIT,
        FCU_DONE
    } fcu_state_e;

    function automatic logic [3:0] opcode4(input logic [FCU_ILEN-1:0] ir);
        return ir[3:0];
    endfunction

    function automatic logic [4:0] funct5(input logic [FCU_ILEN-1:0] ir);
        return ir[39:35];
    endfunction

    function automatic logic is_wait(input logic [FCU_ILEN-1:0] ir);
        return (opcode4(ir) == OPC_BMISC) && (funct5(ir) == FN5_WAIT);
    endfunction

endpackage

// File: rtl/fcu_rr_arb.sv
// fcu_rr_arb: round-robin selector, first request at or above the
// pointer, wrapping from the top entry back to entry 0.
module fcu_rr_arb
    import fcu_pkg::*;
#(
    parameter int QENTRIES = FCU_QENTRIES
) (
    input  logic [QENTRIES-1:0]         req_i,
    input  logic [$clog2(QENTRIES)-1:0] rr_ptr_i,
    output logic [QENTRIES-1:0]         grant_o,
    output logic [$clog2(QENTRIES)-1:0] idx_o,
    output logic                        any_o
);

    localparam int IW = $clog2(QENTRIES);

    int j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int k = 0; k < QENTRIES; k++) begin
            j = int'(rr_ptr_i) + k;
            if (j >= QENTRIES) begin
                j = j - QENTRIES;
            end
            if (!any_o && req_i[j[IW-1:0]]) begin
                any_o               = 1'b1;
                idx_o               = j[IW-1:0];
                grant_o[j[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fcu_issue_ctrl.sv
// fcu_issue_ctrl: FCU issue/completion sequencer IDLE->EXEC->(WAIT)->DONE.
// Optional WAIT timeout counter enabled by FCU_WAIT_TIMEOUT_EN.
module fcu_issue_ctrl
    import fcu_pkg::*;
#(
    parameter int QENTRIES = FCU_QENTRIES,
    parameter int WID      = 80,
    parameter int WAIT_TMO = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [QENTRIES-1:0]         req,
    output logic [QENTRIES-1:0]         grant,
    output logic [$clog2(QENTRIES)-1:0] grant_id,
    output logic                        ld,
    input  logic [FCU_ILEN-1:0]         instr,
    input  logic [WID-1:0]              waitctr,
    input  logic                        irq,
    input  logic                        flush,
    output logic                        done,
    output logic [$clog2(QENTRIES)-1:0] done_id,
    input  logic                        wb_ack,
    output logic                        busy
);

    localparam int IW = $clog2(QENTRIES);

    fcu_state_e            state_q;
    logic [IW-1:0]         rr_ptr_q;
    logic [IW-1:0]         rr_ptr_d;
    logic [IW-1:0]         id_q;
    logic [FCU_ILEN-1:0]   instr_q;
    logic [QENTRIES-1:0]   arb_gnt;
    logic [IW-1:0]         arb_idx;
    logic                  arb_any;
    logic                  issue;
    logic                  wait_hit;

`ifdef FCU_WAIT_TIMEOUT_EN
    localparam int TW = $clog2(WAIT_TMO + 1);

    logic [TW-1:0] tmo_q;
    logic          tmo_hit;

    assign tmo_hit = (tmo_q == TW'(WAIT_TMO - 1));
`endif

    fcu_rr_arb #(
        .QENTRIES (QENTRIES)
    ) u_arb (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (arb_gnt),
        .idx_o    (arb_idx),
        .any_o    (arb_any)
    );

    // Grant is combinational so the entry can drive instr in the same cycle.
    assign issue    = (state_q == FCU_IDLE) && arb_any && !flush && !rst;
    assign grant    = issue ? arb_gnt : '0;
    assign grant_id = issue ? arb_idx : '0;
    assign ld       = issue;

    assign done     = (state_q == FCU_DONE) && !flush;
    assign done_id  = id_q;
    assign busy     = (state_q != FCU_IDLE);

    assign rr_ptr_d = (arb_idx == IW'(QENTRIES - 1)) ? '0 : arb_idx + 1'b1;
    assign wait_hit = (waitctr == WID'(1)) || irq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FCU_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            instr_q  <= '0;
`ifdef FCU_WAIT_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else if (flush) begin
            state_q  <= FCU_IDLE;
`ifdef FCU_WAIT_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                FCU_IDLE: begin
                    if (issue) begin
                        instr_q  <= instr;
                        id_q     <= arb_idx;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= FCU_EXEC;
                    end
                end
                FCU_EXEC: begin
                    if (is_wait(instr_q)) begin
                        state_q <= FCU_WAIT;
`ifdef FCU_WAIT_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                    end else begin
                        state_q <= FCU_DONE;
                    end
                end
                FCU_WAIT: begin
                    if (wait_hit) begin
                        state_q <= FCU_DONE;
                    end
`ifdef FCU_WAIT_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state_q <= FCU_DONE;
                    end else begin
                        tmo_q   <= tmo_q + 1'b1;
                    end
`endif
                end
                FCU_DONE: begin
                    if (wb_ack) begin
                        state_q <= FCU_IDLE;
                    end
                end
                default: state_q <= FCU_IDLE;
            endcase
        end
    end

    a_grant_onehot: assert property (
        @(posedge clk) disable iff (rst) $onehot0(grant));

    a_gid_zero: assert property (
        @(posedge clk) disable iff (rst) (grant == '0) |-> (grant_id == '0));

    a_no_ld_when_busy: assert property (
        @(posedge clk) disable iff (rst) busy |-> !ld);

endmodule
